// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding and the PC step/branch-alignment widths.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    localparam int INSTR_BYTES  = 4;
    localparam int BRANCH_SHIFT = 2;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux: a taken branch target forced to word alignment, otherwise the
// sequential PC + 4 (wrapping modulo 2^64).
module fetch_next_pc
    import fetch_sequencer_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        redirect,
    input  logic [63:0] branch_target,
    output logic [63:0] next_pc
);

    logic [63:0] target_aligned;

    always_comb begin
        target_aligned                     = branch_target;
        target_aligned[BRANCH_SHIFT-1:0]   = '0;
        next_pc = redirect ? target_aligned : pc + 64'(INSTR_BYTES);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD) with redirect
// squashing, decode back-pressure and a sticky memory-response timeout.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          WAIT_LIMIT   = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [63:0] BranchTarget,
    output logic [63:0] CurrentPC,
    output logic [31:0] InstrOut,
    output logic        InstrValid,
    output logic        ImemTimeout
);

    localparam int                CNT_W   = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WAIT_LIMIT);

    fetch_state_e     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             req_q, req_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             squash_q, squash_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [63:0]      next_pc;

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .redirect      (Redirect),
        .branch_target (BranchTarget),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        squash_d  = squash_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        // PC moves only on a redirect (any state) or when HOLD hands off its instruction.
        pc_d = (Redirect || (state_q == ST_HOLD && !Stall)) ? next_pc : pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (ImemGnt) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    squash_d = Redirect;
                end
            end
            ST_WAIT: begin
                if (ImemValid) begin
                    squash_d = 1'b0;
                    if (Redirect || squash_q) begin
                        state_d = ST_REQ;
                    end else begin
                        instr_d = ImemData;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) timeout_d = 1'b1;
                    if (Redirect) squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (Redirect || !Stall) begin
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VECTOR;
            req_q     <= 1'b0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            squash_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            squash_q  <= squash_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ImemReq     = req_q;
    assign ImemAddr    = pc_q;
    assign CurrentPC   = pc_q;
    assign InstrOut    = instr_q;
    assign InstrValid  = valid_q;
    assign ImemTimeout = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed fetch scenarios with a
// scoreboard of (pc, instr) pairs expected to appear on InstrOut.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemValid;
    logic [31:0] ImemData;
    logic        Stall;
    logic        Redirect;
    logic [63:0] BranchTarget;
    logic [63:0] CurrentPC;
    logic [31:0] InstrOut;
    logic        InstrValid;
    logic        ImemTimeout;

    fetch_sequencer dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemGnt      (ImemGnt),
        .ImemValid    (ImemValid),
        .ImemData     (ImemData),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .BranchTarget (BranchTarget),
        .CurrentPC    (CurrentPC),
        .InstrOut     (InstrOut),
        .InstrValid   (InstrValid),
        .ImemTimeout  (ImemTimeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    logic iv_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Each rising edge of InstrValid must match the oldest scoreboard entry.
    always @(negedge CLK) begin
        if (!Reset && InstrValid && !iv_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(InstrValid), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_pc", CurrentPC, e.pc);
                chk("sb_instr", 64'(InstrOut), 64'(e.instr));
            end
        end
        iv_prev = InstrValid;
    end

    task automatic grant(input logic [63:0] exp_addr);
        for (int i = 0; i < 20 && !ImemReq; i++) tick();
        chk("req_seen", 64'(ImemReq), 64'd1);
        chk("req_addr", ImemAddr, exp_addr);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        chk("req_dropped", 64'(ImemReq), 64'd0);
    endtask

    task automatic respond(input logic [63:0] addr, input logic [31:0] data,
                           input int lat, input bit push);
        repeat (lat) tick();
        ImemValid = 1'b1;
        ImemData  = data;
        if (push) sb.push_back('{pc: addr, instr: data});
        tick();
        ImemValid = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int lat);
        grant(addr);
        respond(addr, data, lat, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; ImemGnt = 1'b0; ImemValid = 1'b0; ImemData = '0;
        Stall = 1'b0; Redirect = 1'b0; BranchTarget = '0;
        @(negedge CLK);
        tick(); tick();
        chk("rst_req", 64'(ImemReq), 64'd0);
        chk("rst_valid", 64'(InstrValid), 64'd0);
        chk("rst_instr", 64'(InstrOut), 64'd0);
        chk("rst_pc", CurrentPC, 64'd0);
        chk("rst_timeout", 64'(ImemTimeout), 64'd0);
        Reset = 1'b0;
        tick();

        // Basic fetch, immediate grant, data two cycles later, no stall
        fetch(64'h0, 32'hF800_0000, 2);
        tick();
        chk("seq_addr", ImemAddr, 64'h4);
        chk("seq_valid_clr", 64'(InstrValid), 64'd0);

        // Stall holds the instruction and the PC
        Stall = 1'b1;
        fetch(64'h4, 32'h8B02_0020, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 64'(InstrValid), 64'd1);
            chk("hold_instr", 64'(InstrOut), 64'h8B02_0020);
            chk("hold_pc", CurrentPC, 64'h4);
        end
        Stall = 1'b0;
        tick();
        chk("unstall_pc", CurrentPC, 64'h8);
        chk("unstall_valid", 64'(InstrValid), 64'd0);

        // Redirect in REQ without grant, unaligned target
        Redirect = 1'b1; BranchTarget = 64'h203;
        tick();
        Redirect = 1'b0;
        chk("redir_req_addr", ImemAddr, 64'h200);
        chk("redir_req_req", 64'(ImemReq), 64'd1);

        // Redirect while waiting: response is squashed
        grant(64'h200);
        Redirect = 1'b1; BranchTarget = 64'h100;
        tick();
        Redirect = 1'b0;
        tick();
        respond(64'h200, 32'hDEAD_BEEF, 0, 1'b0);
        chk("squash_valid", 64'(InstrValid), 64'd0);
        chk("squash_addr", ImemAddr, 64'h100);
        fetch(64'h100, 32'h1234_5678, 1);
        tick();
        chk("post_squash_pc", CurrentPC, 64'h104);

        // Redirect coincident with the response
        grant(64'h104);
        Redirect = 1'b1; BranchTarget = 64'h300;
        ImemValid = 1'b1; ImemData = 32'hBAD0_BAD0;
        tick();
        Redirect = 1'b0; ImemValid = 1'b0;
        chk("coinc_valid", 64'(InstrValid), 64'd0);
        chk("coinc_addr", ImemAddr, 64'h300);
        chk("coinc_req", 64'(ImemReq), 64'd1);

        // PC wrap at the top of the address space
        Redirect = 1'b1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        Redirect = 1'b0;
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_0001, 0);
        tick();
        chk("wrap_pc", CurrentPC, 64'h0);

        // Timeout after WAIT_LIMIT silent cycles, sticky until reset
        grant(64'h0);
        repeat (14) tick();
        chk("tmo_early", 64'(ImemTimeout), 64'd0);
        tick();
        chk("tmo_set", 64'(ImemTimeout), 64'd1);
        repeat (5) tick();
        chk("tmo_sat", 64'(ImemTimeout), 64'd1);
        respond(64'h0, 32'h0000_0AAA, 0, 1'b1);
        tick();
        chk("tmo_sticky", 64'(ImemTimeout), 64'd1);
        chk("tmo_pc", CurrentPC, 64'h4);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("tmo_cleared", 64'(ImemTimeout), 64'd0);
        chk("tmo_rst_pc", CurrentPC, 64'h0);
        tick();

        // Redirect beats Stall in HOLD; Reset beats Redirect
        Stall = 1'b1;
        fetch(64'h0, 32'h0000_0BBB, 1);
        Redirect = 1'b1; BranchTarget = 64'h400;
        tick();
        Redirect = 1'b0;
        chk("hold_redir_valid", 64'(InstrValid), 64'd0);
        chk("hold_redir_addr", ImemAddr, 64'h400);
        Reset = 1'b1; Redirect = 1'b1; BranchTarget = 64'h500;
        tick();
        Reset = 1'b0; Redirect = 1'b0; Stall = 1'b0;
        chk("rst_over_redir_pc", CurrentPC, 64'h0);
        chk("rst_over_redir_req", 64'(ImemReq), 64'd0);

        // Late response after reset is ignored in IDLE/REQ
        ImemValid = 1'b1; ImemData = 32'h7777_7777;
        tick(); tick();
        ImemValid = 1'b0;
        chk("late_valid", 64'(InstrValid), 64'd0);
        chk("late_req", 64'(ImemReq), 64'd1);
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
